// File: rtl/dmem_responder_if.sv
// Request/response bus between a load/store initiator and dmem_responder.
// Both channels use valid/ready: a beat transfers on a rising edge where valid and ready are both 1.
interface dmem_responder_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [31:0]           req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [1:0]            req_maskmode;
  logic                  req_sext;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_maskmode, req_sext, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_maskmode, req_sext, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data memory with fixed latency, byte/half/word access and fault checking.
// The memory is read or written on the edge that enters RESP; the response then holds until taken.
module dmem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 64,
  parameter int LATENCY    = 2
) (
  input  logic                clk,
  input  logic                rstn,
  dmem_responder_if.slave     bus,
  output logic [1:0]          o_dbg_state
);
  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

  state_t                r_state, w_next;
  logic [3:0]            r_cnt;
  logic                  r_write, r_sext, r_err;
  logic [31:0]           r_addr;
  logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
  logic [1:0]            r_mm;
  logic [DATA_WIDTH-1:0] r_mem [NUM_WORDS];

  logic                  w_accept, w_enter_resp, w_err;
  logic                  w_a_write, w_a_sext;
  logic [31:0]           w_a_addr;
  logic [DATA_WIDTH-1:0] w_a_wdata, w_word, w_load;
  logic [1:0]            w_a_mm;
  logic [IDX_W-1:0]      w_idx;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;

  assign w_accept     = (r_state == S_IDLE) && bus.req_valid;
  assign w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP);

  // With LATENCY=0 the access happens on the acceptance edge, so use the live request fields.
  assign w_a_write = (r_state == S_IDLE) ? bus.req_write    : r_write;
  assign w_a_addr  = (r_state == S_IDLE) ? bus.req_addr     : r_addr;
  assign w_a_wdata = (r_state == S_IDLE) ? bus.req_wdata    : r_wdata;
  assign w_a_mm    = (r_state == S_IDLE) ? bus.req_maskmode : r_mm;
  assign w_a_sext  = (r_state == S_IDLE) ? bus.req_sext     : r_sext;

  assign w_err = (w_a_mm == 2'b11)
              || ((w_a_mm == 2'b01) && w_a_addr[0])
              || ((w_a_mm == 2'b10) && (w_a_addr[1:0] != 2'b00))
              || ({2'b00, w_a_addr[31:2]} >= NUM_WORDS);

  assign w_idx  = w_a_addr[IDX_W+1:2];
  assign w_word = r_mem[w_idx];
  assign w_byte = w_word[{w_a_addr[1:0], 3'b000} +: 8];
  assign w_half = w_word[{w_a_addr[1], 4'b0000} +: 16];

  always_comb begin
    w_load = w_word;
    case (w_a_mm)
      2'b00:   w_load = {{(DATA_WIDTH-8){w_a_sext & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{(DATA_WIDTH-16){w_a_sext & w_half[15]}}, w_half};
      default: w_load = w_word;
    endcase
  end

  // State register and response registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept)
        r_cnt <= 4'(LATENCY);
      else if (r_state == S_WAIT)
        r_cnt <= r_cnt - 4'd1;
      if (w_enter_resp) begin
        r_err   <= w_err;
        r_rdata <= (w_err || w_a_write) ? '0 : w_load;
      end else if ((r_state == S_RESP) && bus.resp_ready) begin
        r_err   <= 1'b0;
        r_rdata <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_write <= bus.req_write;
      r_addr  <= bus.req_addr;
      r_wdata <= bus.req_wdata;
      r_mm    <= bus.req_maskmode;
      r_sext  <= bus.req_sext;
    end
  end

  // Storage has no reset; a reset that lands before RESP suppresses the commit.
  always_ff @(posedge clk) begin
    if (rstn && w_enter_resp && w_a_write && !w_err) begin
      case (w_a_mm)
        2'b00:   r_mem[w_idx][{w_a_addr[1:0], 3'b000} +: 8] <= w_a_wdata[7:0];
        2'b01:   r_mem[w_idx][{w_a_addr[1], 4'b0000} +: 16] <= w_a_wdata[15:0];
        default: r_mem[w_idx] <= w_a_wdata;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.req_valid) w_next = (LATENCY == 0) ? S_RESP : S_WAIT;
      S_WAIT:  if (r_cnt == 4'd1) w_next = S_RESP;
      S_RESP:  if (bus.resp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (r_state == S_IDLE);
    bus.resp_valid = (r_state == S_RESP);
    bus.resp_rdata = r_rdata;
    bus.resp_err   = r_err;
    o_dbg_state    = r_state;
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance driven from a vector table plus
// hand-written hold/reset sequences, and a LATENCY=0 instance for the zero-wait path.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if #(.DATA_WIDTH(32)) bus_a ();
  dmem_responder_if #(.DATA_WIDTH(32)) bus_z ();
  logic [1:0] dbg_a, dbg_z;

  dmem_responder #(.DATA_WIDTH(32), .NUM_WORDS(64), .LATENCY(2)) u_dut (
    .clk(clk), .rstn(rstn), .bus(bus_a), .o_dbg_state(dbg_a));
  dmem_responder #(.DATA_WIDTH(32), .NUM_WORDS(64), .LATENCY(0)) u_dut0 (
    .clk(clk), .rstn(rstn), .bus(bus_z), .o_dbg_state(dbg_z));

  // Shared driver; sel=1 routes the handshake to the LATENCY=0 instance.
  logic        sel = 1'b0;
  logic        d_valid = 1'b0, d_write = 1'b0, d_sext = 1'b0, d_resp_ready = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic [1:0]  d_mm = 2'b10;

  assign bus_a.req_valid    = d_valid & ~sel;
  assign bus_a.resp_ready   = d_resp_ready & ~sel;
  assign bus_a.req_write    = d_write;
  assign bus_a.req_addr     = d_addr;
  assign bus_a.req_wdata    = d_wdata;
  assign bus_a.req_maskmode = d_mm;
  assign bus_a.req_sext     = d_sext;
  assign bus_z.req_valid    = d_valid & sel;
  assign bus_z.resp_ready   = d_resp_ready & sel;
  assign bus_z.req_write    = d_write;
  assign bus_z.req_addr     = d_addr;
  assign bus_z.req_wdata    = d_wdata;
  assign bus_z.req_maskmode = d_mm;
  assign bus_z.req_sext     = d_sext;

  logic        m_req_ready, m_resp_valid, m_resp_err;
  logic [31:0] m_resp_rdata;
  logic [1:0]  m_dbg;
  assign m_req_ready  = sel ? bus_z.req_ready  : bus_a.req_ready;
  assign m_resp_valid = sel ? bus_z.resp_valid : bus_a.resp_valid;
  assign m_resp_rdata = sel ? bus_z.resp_rdata : bus_a.resp_rdata;
  assign m_resp_err   = sel ? bus_z.resp_err   : bus_a.resp_err;
  assign m_dbg        = sel ? dbg_z : dbg_a;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one request, wait (bounded) for the response, capture it, then complete the handshake.
  task automatic do_req(input string name, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] mm, input logic sx, input int exp_lat,
                        input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    @(negedge clk);
    d_write = w; d_addr = a; d_wdata = wd; d_mm = mm; d_sext = sx; d_valid = 1'b1;
    for (int k = 0; k < 20 && !m_req_ready; k++) @(negedge clk);
    check({name, ".ready"}, {31'd0, m_req_ready}, 32'd1);
    @(posedge clk); #1;
    d_valid = 1'b0;
    lat = 1;
    while (!m_resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, ".lat"}, lat, exp_lat);
    check({name, ".rdata"}, m_resp_rdata, exp_rd);
    check({name, ".err"}, {31'd0, m_resp_err}, {31'd0, exp_err});
    @(negedge clk); d_resp_ready = 1'b1;
    @(posedge clk); #1;
    d_resp_ready = 1'b0;
    check({name, ".idle"}, {30'd0, m_dbg}, 32'd0);
  endtask

  typedef struct {
    string       name;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  mm;
    logic        sx;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[24];
  logic [31:0] held_rd;
  int          waited;

  initial begin
    vecs[0]  = '{"st_w_deadbeef", 1'b1, 32'h10,  32'hDEADBEEF, 2'b10, 1'b0, 32'h0,        1'b0};
    vecs[1]  = '{"ld_w_10",       1'b0, 32'h10,  32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{"st_b_13",       1'b1, 32'h13,  32'h00000080, 2'b00, 1'b0, 32'h0,        1'b0};
    vecs[3]  = '{"ld_b_13_sx",    1'b0, 32'h13,  32'h0,        2'b00, 1'b1, 32'hFFFFFF80, 1'b0};
    vecs[4]  = '{"ld_b_13_zx",    1'b0, 32'h13,  32'h0,        2'b00, 1'b0, 32'h00000080, 1'b0};
    vecs[5]  = '{"ld_w_10_b",     1'b0, 32'h10,  32'h0,        2'b10, 1'b0, 32'h80ADBEEF, 1'b0};
    vecs[6]  = '{"ld_h_11_err",   1'b0, 32'h11,  32'h0,        2'b01, 1'b0, 32'h0,        1'b1};
    vecs[7]  = '{"ld_w_12_err",   1'b0, 32'h12,  32'h0,        2'b10, 1'b0, 32'h0,        1'b1};
    vecs[8]  = '{"ld_mm3_err",    1'b0, 32'h10,  32'h0,        2'b11, 1'b0, 32'h0,        1'b1};
    vecs[9]  = '{"ld_oor_err",    1'b0, 32'h100, 32'h0,        2'b10, 1'b0, 32'h0,        1'b1};
    vecs[10] = '{"st_w_12_err",   1'b1, 32'h12,  32'hCAFEF00D, 2'b10, 1'b0, 32'h0,        1'b1};
    vecs[11] = '{"st_h_11_err",   1'b1, 32'h11,  32'h00001234, 2'b01, 1'b0, 32'h0,        1'b1};
    vecs[12] = '{"st_b_oor_err",  1'b1, 32'h100, 32'h00000055, 2'b00, 1'b0, 32'h0,        1'b1};
    vecs[13] = '{"ld_w_10_keep",  1'b0, 32'h10,  32'h0,        2'b10, 1'b0, 32'h80ADBEEF, 1'b0};
    vecs[14] = '{"st_h_12",       1'b1, 32'h12,  32'hA5A55AC3, 2'b01, 1'b0, 32'h0,        1'b0};
    vecs[15] = '{"ld_h_10_sx",    1'b0, 32'h10,  32'h0,        2'b01, 1'b1, 32'hFFFFBEEF, 1'b0};
    vecs[16] = '{"ld_h_12_sx",    1'b0, 32'h12,  32'h0,        2'b01, 1'b1, 32'h00005AC3, 1'b0};
    vecs[17] = '{"ld_b_11_sx",    1'b0, 32'h11,  32'h0,        2'b00, 1'b1, 32'hFFFFFFBE, 1'b0};
    vecs[18] = '{"st_b_10",       1'b1, 32'h10,  32'hABCDEF11, 2'b00, 1'b0, 32'h0,        1'b0};
    vecs[19] = '{"ld_w_10_sx",    1'b0, 32'h10,  32'h0,        2'b10, 1'b1, 32'h5AC3BE11, 1'b0};
    vecs[20] = '{"st_w_last",     1'b1, 32'hFC,  32'h01020304, 2'b10, 1'b0, 32'h0,        1'b0};
    vecs[21] = '{"ld_b_ff",       1'b0, 32'hFF,  32'h0,        2'b00, 1'b0, 32'h00000001, 1'b0};
    vecs[22] = '{"st_w_20",       1'b1, 32'h20,  32'h0BADF00D, 2'b10, 1'b0, 32'h0,        1'b0};
    vecs[23] = '{"ld_w_20",       1'b0, 32'h20,  32'h0,        2'b10, 1'b0, 32'h0BADF00D, 1'b0};

    // Reset state of both instances.
    repeat (3) @(posedge clk);
    #1;
    check("rst.a.req_ready",  {31'd0, bus_a.req_ready},  32'd1);
    check("rst.a.resp_valid", {31'd0, bus_a.resp_valid}, 32'd0);
    check("rst.a.rdata",      bus_a.resp_rdata,          32'd0);
    check("rst.a.err",        {31'd0, bus_a.resp_err},   32'd0);
    check("rst.z.req_ready",  {31'd0, bus_z.req_ready},  32'd1);
    check("rst.z.resp_valid", {31'd0, bus_z.resp_valid}, 32'd0);
    @(negedge clk); rstn = 1'b1;

    for (int i = 0; i < 24; i++)
      do_req(vecs[i].name, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].mm, vecs[i].sx,
             3, vecs[i].exp_rd, vecs[i].exp_err);

    // Response held with resp_ready low while a new request is presented.
    @(negedge clk);
    d_write = 1'b0; d_addr = 32'h10; d_mm = 2'b10; d_sext = 1'b0; d_valid = 1'b1;
    @(posedge clk); #1;
    d_valid = 1'b0;
    waited = 0;
    while (!m_resp_valid && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check("hold.resp_valid", {31'd0, m_resp_valid}, 32'd1);
    held_rd = 32'h5AC3BE11;
    d_write = 1'b1; d_wdata = 32'h0; d_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("hold.valid",     {31'd0, m_resp_valid}, 32'd1);
      check("hold.rdata",     m_resp_rdata,          held_rd);
      check("hold.err",       {31'd0, m_resp_err},   32'd0);
      check("hold.req_ready", {31'd0, m_req_ready},  32'd0);
    end
    d_valid = 1'b0; d_resp_ready = 1'b1;
    @(posedge clk); #1;
    d_resp_ready = 1'b0;
    check("hold.idle",       {30'd0, m_dbg},        32'd0);
    check("hold.valid_drop", {31'd0, m_resp_valid}, 32'd0);
    do_req("hold.reread", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 3, 32'h5AC3BE11, 1'b0);

    // Reset during WAIT abandons the pending store.
    @(negedge clk);
    d_write = 1'b1; d_addr = 32'h20; d_wdata = 32'h12345678; d_mm = 2'b10; d_valid = 1'b1;
    @(posedge clk); #1;
    d_valid = 1'b0;
    check("rstw.in_wait", {30'd0, m_dbg}, 32'd1);
    @(negedge clk); rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    check("rstw.idle",       {30'd0, m_dbg},        32'd0);
    check("rstw.req_ready",  {31'd0, m_req_ready},  32'd1);
    check("rstw.resp_valid", {31'd0, m_resp_valid}, 32'd0);
    check("rstw.rdata",      m_resp_rdata,          32'd0);
    check("rstw.err",        {31'd0, m_resp_err},   32'd0);
    repeat (4) @(posedge clk);
    do_req("rstw.reread", 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 3, 32'h0BADF00D, 1'b0);

    // Reset during RESP drops the response.
    @(negedge clk);
    d_write = 1'b0; d_addr = 32'h20; d_mm = 2'b10; d_valid = 1'b1;
    @(posedge clk); #1;
    d_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rstr.in_resp", {31'd0, m_resp_valid}, 32'd1);
    @(negedge clk); rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    check("rstr.resp_valid", {31'd0, m_resp_valid}, 32'd0);
    check("rstr.rdata",      m_resp_rdata,          32'd0);
    check("rstr.idle",       {30'd0, m_dbg},        32'd0);

    // Zero-latency instance: response visible right after the acceptance edge.
    sel = 1'b1;
    do_req("z.st_w_4", 1'b1, 32'h4, 32'h11223344, 2'b10, 1'b0, 1, 32'h0, 1'b0);
    do_req("z.ld_w_4", 1'b0, 32'h4, 32'h0, 2'b10, 1'b0, 1, 32'h11223344, 1'b0);
    do_req("z.ld_h_6", 1'b0, 32'h6, 32'h0, 2'b01, 1'b0, 1, 32'h00001122, 1'b0);
    do_req("z.ld_err", 1'b0, 32'h5, 32'h0, 2'b01, 1'b0, 1, 32'h0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
